// File: rtl/rhs_spi_command_tx.sv
// rhs_spi_command_tx
//   SPI command transmitter for one RHS2000 headstage port. Each accepted
//   CMD_WIDTH-bit command is sent MSB first with four dataclk cycles per SPI
//   bit, followed by CS_GAP cycles with CS_b high. It also produces the
//   capture-enable window for the MISO 4x oversampling register, which runs
//   MISO_TAIL cycles past the end of the frame to absorb cable delay, and a
//   one-cycle strobe once that window has closed.
//
// Ports
//   dataclk          system data clock, rising edge
//   reset            asynchronous, active-high reset
//   cmd_word         command to transmit, sampled on accept only
//   cmd_valid        command available
//   cmd_ready        block idle; accept = cmd_valid && cmd_ready
//   CS_b             SPI chip select, active low
//   SCLK             SPI clock (low for phases 0-1, high for phases 2-3)
//   MOSI             SPI data out, changes only at phase 0
//   miso_capture_en  shift-enable for the MISO 4x sample register
//   frame_done       one-cycle pulse after the last capture-enable cycle
//   busy             high whenever the state is not IDLE
//
// Every output is a flop; the next-state logic computes the value each
// output must hold in the following cycle.
module rhs_spi_command_tx #(
  parameter int CMD_WIDTH = 32,
  parameter int CS_GAP    = 8,
  parameter int MISO_TAIL = 6
) (
  input  logic                 dataclk,
  input  logic                 reset,
  input  logic [CMD_WIDTH-1:0] cmd_word,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 CS_b,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic                 miso_capture_en,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CNT_W = $clog2(4 * CMD_WIDTH + CS_GAP + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(4 * CMD_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] TAIL       = CNT_W'(MISO_TAIL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d, cnt_inc;
  logic [CMD_WIDTH-1:0] sreg, sreg_d;
  logic                 cs_d, sclk_d, mosi_d, cap_d, fd_d;
  logic                 accept;

  assign accept  = cmd_valid && cmd_ready;
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sreg_d  = sreg;
    cs_d    = 1'b1;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    cap_d   = 1'b0;
    fd_d    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = cmd_word;
          cs_d    = 1'b0;
          mosi_d  = cmd_word[CMD_WIDTH-1];
          cap_d   = 1'b1;
        end
      end

      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cap_d   = (TAIL != '0);
        end else begin
          cnt_d  = cnt_inc;
          cs_d   = 1'b0;
          cap_d  = 1'b1;
          // Phase is the low two counter bits: SCLK high for phases 2 and 3.
          sclk_d = cnt_inc[1];
          // Advance to the next bit only at phase 0, keeping MOSI stable
          // across the SCLK rising edge.
          if (cnt_inc[1:0] == 2'b00) begin
            sreg_d = sreg << 1;
          end
          mosi_d = sreg_d[CMD_WIDTH-1];
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          cap_d = (cnt_inc < TAIL);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Strobe the cycle after the capture window closes, including the case
    // where it closes exactly on the return to IDLE.
    fd_d = miso_capture_en && !cap_d;
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      CS_b            <= 1'b1;
      SCLK            <= 1'b0;
      MOSI            <= 1'b0;
      miso_capture_en <= 1'b0;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
      cmd_ready       <= 1'b1;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      CS_b            <= cs_d;
      SCLK            <= sclk_d;
      MOSI            <= mosi_d;
      miso_capture_en <= cap_d;
      frame_done      <= fd_d;
      busy            <= (state_d != IDLE);
      cmd_ready       <= (state_d == IDLE);
    end
  end

  // Command shift register carries data only; its contents are irrelevant
  // until the next accept reloads it.
  always_ff @(posedge dataclk) begin
    sreg <= sreg_d;
  end

endmodule

// File: tb/tb_rhs_spi_command_tx.sv
module tb_rhs_spi_command_tx;

  logic        dataclk = 1'b0;
  logic        reset;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready, CS_b, SCLK, MOSI, miso_capture_en, frame_done, busy;

  logic [15:0] b_word;
  logic        b_valid;
  logic        b_ready, b_cs, b_sclk, b_mosi, b_cap, b_fd, b_busy;

  always #5 dataclk = ~dataclk;

  rhs_spi_command_tx dut (
    .dataclk(dataclk), .reset(reset), .cmd_word(cmd_word), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .CS_b(CS_b), .SCLK(SCLK), .MOSI(MOSI),
    .miso_capture_en(miso_capture_en), .frame_done(frame_done), .busy(busy)
  );

  rhs_spi_command_tx #(.CMD_WIDTH(16), .CS_GAP(6), .MISO_TAIL(6)) dut16 (
    .dataclk(dataclk), .reset(reset), .cmd_word(b_word), .cmd_valid(b_valid),
    .cmd_ready(b_ready), .CS_b(b_cs), .SCLK(b_sclk), .MOSI(b_mosi),
    .miso_capture_en(b_cap), .frame_done(b_fd), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  logic tr_cs   [0:399];
  logic tr_sclk [0:399];
  logic tr_mosi [0:399];
  logic tr_cap  [0:399];
  logic tr_fd   [0:399];
  logic tr_rdy  [0:399];
  logic tr_busy [0:399];

  typedef struct {
    logic [31:0] word;
    int          ones;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int j);
    tr_cs[j]   = CS_b;
    tr_sclk[j] = SCLK;
    tr_mosi[j] = MOSI;
    tr_cap[j]  = miso_capture_en;
    tr_fd[j]   = frame_done;
    tr_rdy[j]  = cmd_ready;
    tr_busy[j] = busy;
  endtask

  // Presents w in cycle k (sampled as trace index 0) and returns just after
  // the accept edge; the caller decides when to drop cmd_valid.
  task automatic start(input logic [31:0] w);
    @(negedge dataclk);
    check("ready_before_accept", cmd_ready, 1);
    cmd_word  = w;
    cmd_valid = 1'b1;
    sample(0);
    @(posedge dataclk);
  endtask

  // Checks one default-parameter frame whose first SHIFT cycle is trace index b.
  task automatic analyze(input string tag, input logic [31:0] w, input int b);
    int          e_sclk, e_mosi, cs_lo, cs_hi, cap_n, fd_n, e_busy, rises;
    logic [31:0] rec;
    e_sclk = 0; e_mosi = 0; cs_lo = 0; cs_hi = 0;
    cap_n = 0; fd_n = 0; e_busy = 0; rises = 0; rec = '0;
    for (int c = 0; c < 128; c++) begin
      if (tr_sclk[b+c] !== ((c % 4) >= 2)) e_sclk++;
      if (tr_mosi[b+c] !== w[31 - c/4]) e_mosi++;
      if (tr_cs[b+c] === 1'b0) cs_lo++;
      if ((c % 4) == 2) rec = {rec[30:0], tr_mosi[b+c]};
    end
    for (int j = b + 128; j < b + 136; j++) begin
      if (tr_cs[j] === 1'b1) cs_hi++;
      if (tr_sclk[j] !== 1'b0) e_sclk++;
      if (tr_mosi[j] !== 1'b0) e_mosi++;
    end
    for (int j = b; j <= b + 136; j++) begin
      if (tr_cap[j] === 1'b1) cap_n++;
      if (tr_fd[j] === 1'b1) fd_n++;
      if (tr_busy[j] !== !tr_rdy[j]) e_busy++;
      if (tr_sclk[j-1] === 1'b0 && tr_sclk[j] === 1'b1) rises++;
    end
    check({tag, "_sclk_pattern_errs"}, e_sclk, 0);
    check({tag, "_mosi_errs"}, e_mosi, 0);
    check({tag, "_word"}, rec, w);
    check({tag, "_cs_low_cycles"}, cs_lo, 128);
    check({tag, "_cs_gap_high"}, cs_hi, 8);
    check({tag, "_cap_cycles"}, cap_n, 134);
    check({tag, "_cap_last"}, {tr_cap[b+133], tr_cap[b+134]}, 2'b10);
    check({tag, "_fd_count"}, fd_n, 1);
    check({tag, "_fd_pos_k135"}, tr_fd[b+134], 1);
    check({tag, "_sclk_rises"}, rises, 32);
    check({tag, "_ready_k136_k137"}, {tr_rdy[b+135], tr_rdy[b+136]}, 2'b01);
    check({tag, "_busy_vs_ready"}, e_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cs_lo, cap_n, fd_n, fd_pos, rdy_first, rises;
    logic        prev_sclk;
    logic [15:0] rec16;

    vt[0] = '{32'h8000_0001, 2};
    vt[1] = '{32'hA5A5_A5A5, 16};
    vt[2] = '{32'h5A5A_5A5A, 16};
    vt[3] = '{32'hFFFF_FFFF, 32};
    vt[4] = '{32'h0000_0000, 0};
    vt[5] = '{32'h1234_5678, 13};

    reset = 1'b1; cmd_valid = 1'b0; cmd_word = '0;
    b_valid = 1'b0; b_word = '0;
    #2;
    check("rst_async_outputs", {CS_b, SCLK, MOSI, cmd_ready, miso_capture_en, frame_done, busy}, 7'b1001000);
    check("rst_async_outputs16", {b_cs, b_sclk, b_mosi, b_ready, b_cap, b_fd, b_busy}, 7'b1001000);
    repeat (3) @(posedge dataclk);
    @(negedge dataclk);
    check("rst_held_outputs", {CS_b, SCLK, MOSI, cmd_ready, miso_capture_en, frame_done, busy}, 7'b1001000);
    reset = 1'b0;
    repeat (2) @(negedge dataclk);
    check("idle_after_reset", {CS_b, SCLK, MOSI, cmd_ready, miso_capture_en, frame_done, busy}, 7'b1001000);

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      start(vt[v].word);
      for (int j = 1; j <= 140; j++) begin
        @(negedge dataclk);
        sample(j);
        if (j == 1) cmd_valid = 1'b0;
      end
      analyze($sformatf("vec%0d", v), vt[v].word, 1);
      n = 0;
      for (int j = 1; j <= 136; j++) if (tr_mosi[j] === 1'b1) n++;
      check($sformatf("vec%0d_mosi_high_cycles", v), n, 4 * vt[v].ones);
    end

    // cmd_valid held high: back-to-back frames, word changed after first accept.
    start(32'hA5A5_A5A5);
    for (int j = 1; j <= 280; j++) begin
      @(negedge dataclk);
      sample(j);
      if (j == 1) cmd_word = 32'h5A5A_5A5A;
      if (j == 138) cmd_valid = 1'b0;
    end
    analyze("b2b_first", 32'hA5A5_A5A5, 1);
    n = 0;
    for (int j = 129; j <= 137; j++) if (tr_cs[j] === 1'b1) n++;
    check("b2b_cs_high_between", n, 9);
    check("b2b_cs_edges", {tr_cs[128], tr_cs[138]}, 2'b00);
    check("b2b_ready_k137", tr_rdy[137], 1);
    analyze("b2b_second", 32'h5A5A_5A5A, 138);

    // cmd_valid pulsed mid-frame with another word: must be ignored.
    start(32'h8000_0001);
    for (int j = 1; j <= 140; j++) begin
      @(negedge dataclk);
      sample(j);
      if (j == 1) cmd_valid = 1'b0;
      if (j == 50) begin cmd_valid = 1'b1; cmd_word = 32'hFFFF_FFFF; end
      if (j == 51) cmd_valid = 1'b0;
    end
    analyze("ignore", 32'h8000_0001, 1);
    n = 0;
    for (int j = 1; j <= 136; j++) if (tr_rdy[j] === 1'b1) n++;
    check("ignore_ready_low_cycles", n, 0);

    // Reset asserted mid-frame.
    start(32'hFFFF_FFFF);
    for (int j = 1; j <= 60; j++) begin
      @(negedge dataclk);
      sample(j);
      if (j == 1) cmd_valid = 1'b0;
    end
    check("midrst_pre_state", {tr_cs[60], tr_sclk[60], tr_mosi[60], tr_cap[60]}, 4'b0111);
    reset = 1'b1;
    #1;
    check("midrst_async_outputs", {CS_b, SCLK, MOSI, cmd_ready, miso_capture_en, frame_done, busy}, 7'b1001000);
    repeat (2) @(posedge dataclk);
    @(negedge dataclk);
    reset = 1'b0;
    fd_n = 0; cs_lo = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge dataclk);
      if (frame_done === 1'b1) fd_n++;
      if (CS_b === 1'b0) cs_lo++;
    end
    check("midrst_no_frame_done", fd_n, 0);
    check("midrst_no_cs_activity", cs_lo, 0);
    start(32'h1234_5678);
    for (int j = 1; j <= 140; j++) begin
      @(negedge dataclk);
      sample(j);
      if (j == 1) cmd_valid = 1'b0;
    end
    analyze("after_rst", 32'h1234_5678, 1);

    // Parameter sweep instance: CMD_WIDTH=16, CS_GAP=6, MISO_TAIL=6.
    @(negedge dataclk);
    check("w16_ready_before_accept", b_ready, 1);
    b_word  = 16'hC3A5;
    b_valid = 1'b1;
    prev_sclk = b_sclk;
    @(posedge dataclk);
    cs_lo = 0; cap_n = 0; fd_n = 0; fd_pos = -1; rdy_first = -1; rises = 0; rec16 = '0;
    for (int j = 1; j <= 80; j++) begin
      @(negedge dataclk);
      if (j == 1) b_valid = 1'b0;
      if (b_cs === 1'b0) cs_lo++;
      if (b_cap === 1'b1) cap_n++;
      if (b_fd === 1'b1) begin fd_n++; fd_pos = j; end
      if (b_ready === 1'b1 && rdy_first < 0) rdy_first = j;
      if (prev_sclk === 1'b0 && b_sclk === 1'b1) begin
        rises++;
        rec16 = {rec16[14:0], b_mosi};
      end
      prev_sclk = b_sclk;
      if (j == 71) check("w16_fd_with_ready", {b_fd, b_ready, b_busy}, 3'b110);
    end
    check("w16_cs_low_cycles", cs_lo, 64);
    check("w16_cap_cycles", cap_n, 70);
    check("w16_fd_count", fd_n, 1);
    check("w16_fd_pos", fd_pos, 71);
    check("w16_ready_first", rdy_first, 71);
    check("w16_sclk_rises", rises, 16);
    check("w16_word", rec16, 16'hC3A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
